// File: rtl/ervp_mailbox_register_pkg.sv
// ---------------------------------------------------------------------------
// ervp_global : shared constants and width helpers for the ervp mailbox slice.
//
// Contents
//   MODE_BLOCK / MODE_OVERWRITE : values for the mailbox OVERWRITE parameter
//   f_clog2     : ceil(log2(value)), 0 for value <= 1
//   f_bw_ptr    : pointer width for a DEPTH-entry ring, never below 1 bit
//   f_bw_count  : occupancy counter width able to hold 0..DEPTH
// ---------------------------------------------------------------------------
package ervp_global;

    localparam int MODE_BLOCK     = 32'sd0;
    localparam int MODE_OVERWRITE = 32'sd1;

    // Bounded loop so the function stays a plain elaboration-time constant.
    function automatic int f_clog2(input int value);
        int result;
        result = 32'sd0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 32'sd1;
            end
        end
        return result;
    endfunction

    // A DEPTH=1 ring still needs a 1-bit pointer so the ports are never zero-width.
    function automatic int f_bw_ptr(input int depth);
        int bits;
        bits = f_clog2(depth);
        if (bits < 32'sd1) begin
            bits = 32'sd1;
        end
        return bits;
    endfunction

    // The count must reach DEPTH itself, hence DEPTH+1 states.
    function automatic int f_bw_count(input int depth);
        return f_clog2(depth + 32'sd1);
    endfunction

endpackage

// File: rtl/ervp_mailbox_register_wrap_counter.sv
// ---------------------------------------------------------------------------
// ervp_wrap_counter : modulo-DEPTH pointer used for the mailbox read and
// write positions.
//
// Ports
//   clk    in   clock, rising edge
//   rstnn  in   asynchronous active-low reset, value -> 0
//   clear  in   synchronous return to 0, wins over inc
//   inc    in   advance by one, wrapping DEPTH-1 -> 0
//   value  out  current pointer (registered)
// ---------------------------------------------------------------------------
module ervp_wrap_counter
    import ervp_global::*;
#(
    parameter int DEPTH  = 4,
    parameter int BW_PTR = f_bw_ptr(DEPTH)
) (
    input  logic              clk,
    input  logic              rstnn,
    input  logic              clear,
    input  logic              inc,
    output logic [BW_PTR-1:0] value
);

    localparam logic [BW_PTR-1:0] LAST_C = BW_PTR'(DEPTH - 32'sd1);

    logic [BW_PTR-1:0] value_r;
    logic [BW_PTR-1:0] value_next_s;

    // Next pointer value: clear first, then wrap-aware increment.
    always_comb begin
        value_next_s = value_r;
        if (clear) begin
            value_next_s = {BW_PTR{1'b0}};
        end else if (inc) begin
            if (value_r == LAST_C) begin
                value_next_s = {BW_PTR{1'b0}};
            end else begin
                value_next_s = value_r + BW_PTR'(1'b1);
            end
        end else begin
            value_next_s = value_r;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            value_r <= {BW_PTR{1'b0}};
        end else begin
            value_r <= value_next_s;
        end
    end

    assign value = value_r;

endmodule

// File: rtl/ervp_mailbox_register.sv
// ---------------------------------------------------------------------------
// ervp_mailbox_register : DEPTH-entry single-clock mailbox with
// wrequest/wready and rrequest/rready handshakes, optional overwrite of the
// oldest entry when full, occupancy count, synchronous flush and a drop pulse.
//
// Ports
//   clk       in   clock, rising edge
//   rstnn     in   asynchronous active-low reset
//   flush     in   synchronous clear of pointers/count (storage untouched)
//   wready    out  a write will be accepted this cycle
//   wrequest  in   producer write strobe
//   wdata     in   write data
//   rready    out  head entry valid
//   rrequest  in   consumer pop strobe
//   rdata     out  head entry, first-word fall-through from registers
//   count     out  number of valid entries, 0..DEPTH
//   dropped   out  one-cycle pulse after an entry was discarded by overwrite
// ---------------------------------------------------------------------------
module ervp_mailbox_register
    import ervp_global::*;
#(
    parameter int BW_DATA   = 8,
    parameter int DEPTH     = 4,
    parameter int OVERWRITE = MODE_BLOCK,
    localparam int BW_COUNT = f_bw_count(DEPTH),
    localparam int BW_PTR   = f_bw_ptr(DEPTH)
) (
    input  logic                clk,
    input  logic                rstnn,
    input  logic                flush,
    output logic                wready,
    input  logic                wrequest,
    input  logic [BW_DATA-1:0]  wdata,
    output logic                rready,
    input  logic                rrequest,
    output logic [BW_DATA-1:0]  rdata,
    output logic [BW_COUNT-1:0] count,
    output logic                dropped
);

    localparam logic                OVR_EN_C = (OVERWRITE == MODE_OVERWRITE) ? 1'b1 : 1'b0;
    localparam logic [BW_COUNT-1:0] FULL_C   = BW_COUNT'(DEPTH);

    logic [BW_DATA-1:0]  storage_r [DEPTH];
    logic [BW_COUNT-1:0] count_r;
    logic                dropped_r;

    logic [BW_PTR-1:0]   wptr_s;
    logic [BW_PTR-1:0]   rptr_s;
    logic                full_s;
    logic                accept_s;
    logic                pop_s;
    logic                write_en_s;
    logic                winc_s;
    logic                rinc_s;
    logic                drop_event_s;
    logic [BW_COUNT-1:0] count_next_s;

    assign full_s   = (count_r == FULL_C);
    assign wready   = !full_s | OVR_EN_C;
    assign rready   = (count_r != {BW_COUNT{1'b0}});
    assign accept_s = wrequest & wready;
    assign pop_s    = rrequest & rready;

    // Event decode. A write into a full mailbox without a matching pop can
    // only be accepted in overwrite mode, and it must push the head forward.
    always_comb begin
        write_en_s   = 1'b0;
        winc_s       = 1'b0;
        rinc_s       = 1'b0;
        drop_event_s = 1'b0;
        if (flush) begin
            write_en_s   = 1'b0;
            winc_s       = 1'b0;
            rinc_s       = 1'b0;
            drop_event_s = 1'b0;
        end else begin
            drop_event_s = accept_s & !pop_s & full_s;
            write_en_s   = accept_s;
            winc_s       = accept_s;
            rinc_s       = pop_s | drop_event_s;
        end
    end

    // Occupancy update: a simultaneous accept+pop, or an overwrite, keeps it.
    always_comb begin
        count_next_s = count_r;
        if (flush) begin
            count_next_s = {BW_COUNT{1'b0}};
        end else if (accept_s && !pop_s && !full_s) begin
            count_next_s = count_r + BW_COUNT'(1'b1);
        end else if (pop_s && !accept_s) begin
            count_next_s = count_r - BW_COUNT'(1'b1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Count and drop-pulse registers.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            count_r   <= {BW_COUNT{1'b0}};
            dropped_r <= 1'b0;
        end else begin
            count_r   <= count_next_s;
            dropped_r <= drop_event_s;
        end
    end

    // Entry storage; reset clear keeps rdata deterministic, flush leaves it alone.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            for (int i = 0; i < DEPTH; i++) begin
                storage_r[i] <= {BW_DATA{1'b0}};
            end
        end else if (write_en_s) begin
            storage_r[wptr_s] <= wdata;
        end
    end

    ervp_wrap_counter #(
        .DEPTH  (DEPTH),
        .BW_PTR (BW_PTR)
    ) u_wptr (
        .clk   (clk),
        .rstnn (rstnn),
        .clear (flush),
        .inc   (winc_s),
        .value (wptr_s)
    );

    ervp_wrap_counter #(
        .DEPTH  (DEPTH),
        .BW_PTR (BW_PTR)
    ) u_rptr (
        .clk   (clk),
        .rstnn (rstnn),
        .clear (flush),
        .inc   (rinc_s),
        .value (rptr_s)
    );

    assign rdata   = storage_r[rptr_s];
    assign count   = count_r;
    assign dropped = dropped_r;

endmodule
